lcd_message_streamer: RTL
=========================

// Module: lcd_message_streamer
// PURPOSE
//   Upstream feeder for the 4-bit text LCD driver. Holds a 2x16 character frame buffer written by
//   game/control logic. On a refresh request it streams the whole frame to the driver, one byte per
//   handshake: a line-address command, then 16 characters, for each of the two lines.
//   Lets the rest of the design update text by address without touching LCD timing.
// PARAMETERS
//   COLS        16    characters per line (fixed for the 1602 panel; buffer depth = 2*COLS)
//   GAP_CYCLES  100   idle clk cycles enforced after each accepted byte before the next is offered
//   BLANK_CHAR  8'h20 reset fill value and substitute for non-printable codes
// PORTS
//   clk         in   1  system clock
//   rst         in   1  synchronous, active-high reset
//   wr_en       in   1  frame-buffer write strobe
//   wr_addr     in   5  buffer address: 0-15 = line 0, 16-31 = line 1
//   wr_data     in   8  ASCII code to store
//   refresh     in   1  single-cycle request to stream the full frame
//   lcd_ready   in   1  driver can accept a byte this cycle
//   data_in     out  8  byte to driver (command or character)
//   is_cmd      out  1  1 = data_in is an LCD command (RS=0); 0 = character (RS=1)
//   data_valid  out  1  data_in/is_cmd valid; held until accepted
//   write_text  out  1  high for the whole streaming session
//   busy        out  1  streaming in progress
//   done        out  1  one-cycle pulse after the last character of line 1 is accepted
// BEHAVIOUR
//   Reset: every output 0; FSM -> IDLE; pending flag cleared; all 32 buffer entries = BLANK_CHAR.
//   Buffer writes: a write with wr_en=1 lands at the next clk edge and is legal in any state.
//     - A character is read when it is issued. A write to an entry that is not yet sent shows up
//       in the current pass.
//     - wr_addr is 5 bits, so no address is out of range.
//   Transfer: a byte moves on any cycle where data_valid && lcd_ready are both 1.
//     - data_in and is_cmd stay stable while data_valid=1 && !lcd_ready.
//     - data_valid drops the cycle after acceptance.
//   FSM states:
//     IDLE     busy=0, write_text=0. Moves to ADDR (line=0) when refresh=1 or pending=1;
//              pending clears on entry.
//     ADDR     is_cmd=1. data_in = 8'h80 for line 0, 8'hC0 for line 1. On accept -> GAP, col=0.
//     CHAR     is_cmd=0. data_in = buf[line*COLS+col], passed through the sanitise rule.
//              On accept -> GAP.
//     GAP      gap counter runs 0..GAP_CYCLES-1 with data_valid=0. When it expires, the next state is
//              decided by the last accepted byte:
//                - after ADDR: go to CHAR
//                - after a CHAR with col<COLS-1: col+1, go to CHAR
//                - after a CHAR with col=COLS-1 and line=0: line=1, go to ADDR
//                - after a CHAR with col=COLS-1 and line=1: go to IDLE
//              The line-1 last-character accept also pulses done (the cycle after acceptance).
//   Sanitise: codes below 8'h20 or above 8'h7E are sent as BLANK_CHAR; the stored value is unchanged.
//   Streaming outputs: busy=1 and write_text=1 in ADDR, CHAR and GAP.
//   Latency:
//     - refresh to first data_valid: 1 cycle.
//     - Full frame with lcd_ready held high: 34 bytes x (1 + GAP_CYCLES) cycles.
//   Refresh while busy: sets pending (one deep; further requests merge). After done, the FSM goes
//     IDLE -> ADDR, so busy drops for exactly one cycle.
//   Refresh in the same cycle as the final accept: counted as pending; a second pass follows.
//   Reset mid-stream: aborts at once, with no done pulse. The buffer is re-blanked.
//   Widths: col is 4 bits and line is 1 bit. The buffer index is {line,col}, with no arithmetic
//     overflow. The gap counter is wide enough for GAP_CYCLES (clog2).
// STRUCTURE
//   lcd_pkg: LCD_CMD_LINE0=8'h80, LCD_CMD_LINE1=8'hC0, LCD_COLS=16, ASCII_SPACE=8'h20,
//     ASCII_MAX=8'h7E, state encoding (IDLE/ADDR/CHAR/GAP).
//   Sub-module lcd_char_buffer: 32x8 register array with one sync write port and one async read port,
//     reset-filled with BLANK_CHAR.
//   The FSM, counters and sanitise logic stay in the top.
// TESTING
//   1) Reset, then refresh with lcd_ready=1 ->
//      - 34 bytes: 80, 16x20, C0, 16x20; is_cmd=1 only on 80 and C0.
//      - Gaps are exactly GAP_CYCLES; done pulses once; busy is low afterwards.
//   2) Write "HELLO" at addr 0-4 and 'A'(8'h41) at addr 31, then refresh ->
//      - line 0 starts 48 45 4C 4C 4F then 11x20; the last byte is 41.
//   3) lcd_ready low for 7 cycles while the first CHAR is offered ->
//      - data_valid stays 1 and data_in does not change; one accept when ready rises.
//   4) refresh pulsed twice during one stream ->
//      - exactly two full passes; busy low for one cycle between them; two done pulses.
//   5) Store 8'h07 and 8'h7F at addr 3 and 4 -> both sent as 8'h20; the stored bytes are unchanged.
//   6) rst asserted on the 10th byte -> next cycle:
//      - all outputs 0 and no done pulse.
//      - a later refresh sends an all-blank frame.

Source files
------------

// File: rtl/lcd_message_streamer_pkg.sv
// Shared constants, state encoding and the printable-character filter for the LCD message streamer.
package lcd_message_streamer_pkg;

    localparam logic [7:0] LCD_CMD_LINE0 = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE1 = 8'hC0;
    localparam int         LCD_COLS      = 16;
    localparam int         LCD_DEPTH     = 2 * LCD_COLS;
    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_MAX     = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_CHAR = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // Codes the panel cannot render are shown as the blank character instead.
    function automatic logic [7:0] sanitise(input logic [7:0] code, input logic [7:0] blank);
        return ((code < ASCII_SPACE) || (code > ASCII_MAX)) ? blank : code;
    endfunction

endpackage

// File: rtl/lcd_message_streamer_if.sv
// Frame-buffer write port, refresh request and byte handshake towards the LCD driver.
// Handshake: a byte moves on every cycle where data_valid && lcd_ready; while data_valid is high
// and lcd_ready is low, data_in and is_cmd hold their value; data_valid drops after acceptance.
interface lcd_message_streamer_if;
    import lcd_message_streamer_pkg::*;

    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       refresh;
    logic       lcd_ready;
    logic [7:0] data_in;
    logic       is_cmd;
    logic       data_valid;
    logic       write_text;
    logic       busy;
    logic       done;
    state_e     dbg_state;

    modport master (
        output wr_en, wr_addr, wr_data, refresh, lcd_ready,
        input  data_in, is_cmd, data_valid, write_text, busy, done, dbg_state
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, refresh, lcd_ready,
        output data_in, is_cmd, data_valid, write_text, busy, done, dbg_state
    );

endinterface

// File: rtl/lcd_message_streamer_char_buffer.sv
// 2x16 character store: one synchronous write port, one asynchronous read port, reset to blanks.
module lcd_message_streamer_char_buffer #(
    parameter int         AW         = 5,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    localparam int DEPTH = 2 ** AW;

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= BLANK_CHAR;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/lcd_message_streamer.sv
// Streams the 2x16 frame to the LCD driver: line command then 16 characters, for each line,
// with a fixed idle gap after every accepted byte.
module lcd_message_streamer
    import lcd_message_streamer_pkg::*;
#(
    parameter int         COLS       = LCD_COLS,
    parameter int         GAP_CYCLES = 100,
    parameter logic [7:0] BLANK_CHAR = ASCII_SPACE
) (
    input  logic                  clk,
    input  logic                  rst,
    lcd_message_streamer_if.slave bus
);
    localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] LAST_GAP = GW'(GAP_CYCLES - 1);
    localparam logic [3:0]    LAST_COL = 4'(COLS - 1);

    state_e        state_q, state_d;
    logic          line_q, line_d;
    logic [3:0]    col_q, col_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          after_addr_q, after_addr_d;
    logic          pending_q, pending_d;
    logic          done_q, done_d;
    logic [7:0]    char_q, char_d;

    logic [3:0]    next_col;
    logic [4:0]    rd_addr;
    logic [7:0]    rd_data;

    logic          offer_valid;
    logic          offer_cmd;
    logic [7:0]    offer_data;
    logic          streaming;

    // During the gap the buffer is addressed at the character that will be issued next,
    // so it is captured exactly when the CHAR state is entered and held stable afterwards.
    assign next_col = col_q + 4'd1;
    assign rd_addr  = {line_q, after_addr_q ? col_q : next_col};

    lcd_message_streamer_char_buffer #(
        .AW         (5),
        .BLANK_CHAR (BLANK_CHAR)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        col_d        = col_q;
        gap_d        = gap_q;
        after_addr_d = after_addr_q;
        pending_d    = pending_q;
        done_d       = 1'b0;
        char_d       = char_q;
        offer_valid  = 1'b0;
        offer_cmd    = 1'b0;
        offer_data   = 8'h00;
        streaming    = 1'b1;

        // Requests arriving mid-stream merge into a single follow-up pass.
        if (bus.refresh && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                streaming = 1'b0;
                if (bus.refresh || pending_q) begin
                    state_d   = ST_ADDR;
                    line_d    = 1'b0;
                    col_d     = 4'd0;
                    pending_d = 1'b0;
                end
            end
            ST_ADDR: begin
                offer_valid = 1'b1;
                offer_cmd   = 1'b1;
                offer_data  = line_q ? LCD_CMD_LINE1 : LCD_CMD_LINE0;
                if (bus.lcd_ready) begin
                    state_d      = ST_GAP;
                    gap_d        = '0;
                    col_d        = 4'd0;
                    after_addr_d = 1'b1;
                end
            end
            ST_CHAR: begin
                offer_valid = 1'b1;
                offer_data  = char_q;
                if (bus.lcd_ready) begin
                    state_d      = ST_GAP;
                    gap_d        = '0;
                    after_addr_d = 1'b0;
                    if (line_q && (col_q == LAST_COL)) begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == LAST_GAP) begin
                    if (after_addr_q) begin
                        state_d = ST_CHAR;
                        char_d  = sanitise(rd_data, BLANK_CHAR);
                    end else if (col_q != LAST_COL) begin
                        state_d = ST_CHAR;
                        col_d   = next_col;
                        char_d  = sanitise(rd_data, BLANK_CHAR);
                    end else if (!line_q) begin
                        state_d = ST_ADDR;
                        line_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            line_q       <= 1'b0;
            col_q        <= 4'd0;
            gap_q        <= '0;
            after_addr_q <= 1'b0;
            pending_q    <= 1'b0;
            done_q       <= 1'b0;
            char_q       <= BLANK_CHAR;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            col_q        <= col_d;
            gap_q        <= gap_d;
            after_addr_q <= after_addr_d;
            pending_q    <= pending_d;
            done_q       <= done_d;
            char_q       <= char_d;
        end
    end

    assign bus.data_in    = offer_data;
    assign bus.is_cmd     = offer_cmd;
    assign bus.data_valid = offer_valid;
    assign bus.write_text = streaming;
    assign bus.busy       = streaming;
    assign bus.done       = done_q;
    assign bus.dbg_state  = state_q;

endmodule
